data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 134 +++++++++++++
 tb/tb_data_mem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Slave end of the core's data req/gnt/rvalid interface, with a word-addressed,
// byte-lane-writable RAM and configurable grant delay and response latency.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_2800,
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned GNT_WAIT       = 0,
    parameter int unsigned RVALID_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] req_count_o
);
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned LAT_W  = 3;
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GNT_WAIT,
        S_LAT
    } state_t;

    state_t              state, state_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;
    logic [LAT_W-1:0]    lat_cnt, lat_cnt_next;
    logic                gnt_c;
    logic                rvalid_c;
    logic                handshake;
    logic                in_range;
    logic [31:0]         offset;
    logic [IDX_W-1:0]    idx;
    logic [31:0]         resp_rdata;
    logic                resp_err;
    logic [31:0]         mem [MEM_WORDS];

    assign offset   = data_addr_i - BASE_ADDR;
    assign idx      = IDX_W'(offset >> 2);
    assign in_range = ({1'b0, data_addr_i} >= 33'(BASE_ADDR)) && ({1'b0, data_addr_i} < END_ADDR);

    // Next-state, grant and response-strobe decode
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        lat_cnt_next  = lat_cnt;
        gnt_c         = 1'b0;
        rvalid_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (data_req_i) begin
                    if (GNT_WAIT == 0) begin
                        gnt_c      = 1'b1;
                        state_next = S_LAT;
                    end else begin
                        wait_cnt_next = WAIT_W'(1);
                        state_next    = S_GNT_WAIT;
                    end
                end
            end
            S_GNT_WAIT: begin
                if (!data_req_i) begin
                    wait_cnt_next = '0;
                    state_next    = S_IDLE;
                end else if (wait_cnt == WAIT_W'(GNT_WAIT)) begin
                    gnt_c         = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = S_LAT;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end
            end
            S_LAT: begin
                if (lat_cnt == '0) begin
                    rvalid_c   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    lat_cnt_next = lat_cnt - LAT_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (gnt_c) begin
            lat_cnt_next = LAT_W'(RVALID_LATENCY - 1);
        end
    end

    assign data_gnt_o    = gnt_c && !reset;
    assign handshake     = data_req_i && data_gnt_o;
    assign data_rvalid_o = rvalid_c && !reset;
    assign data_rdata_o  = data_rvalid_o ? resp_rdata : 32'h0;
    assign data_err_o    = data_rvalid_o && resp_err;

    // State, counters and the response captured at the handshake edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            lat_cnt     <= '0;
            resp_rdata  <= 32'h0;
            resp_err    <= 1'b0;
            req_count_o <= 32'h0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            lat_cnt  <= lat_cnt_next;
            if (handshake) begin
                req_count_o <= req_count_o + 32'd1;
                resp_rdata  <= (in_range && !data_we_i) ? mem[idx] : 32'h0;
                resp_err    <= !in_range;
            end
        end
    end

    // RAM is deliberately not reset; committed writes survive a reset
    always_ff @(posedge clk) begin
        if (handshake && data_we_i && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (data_be_i[i]) begin
                    mem[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder: three instances with different
// grant/latency settings are checked against a transaction-level memory model.
module tb_data_mem_responder;
    localparam int NI = 3;
    localparam int G_OF [NI] = '{0, 3, 2};
    localparam int L_OF [NI] = '{1, 4, 3};
    localparam logic [31:0] BASE = 32'h0000_2800;
    localparam logic [31:0] SPAN = 32'h0000_1000;

    logic        clk;
    logic        rst   [NI];
    logic        req   [NI];
    logic [31:0] addr  [NI];
    logic        we    [NI];
    logic [3:0]  be    [NI];
    logic [31:0] wdata [NI];
    logic        gnt   [NI];
    logic        rvalid[NI];
    logic [31:0] rdata [NI];
    logic        err   [NI];
    logic [31:0] cnt   [NI];

    logic [31:0] mm [NI][1024];
    logic [31:0] exp_cnt [NI];
    int total = 0;
    int bad   = 0;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        data_mem_responder #(
            .BASE_ADDR      (BASE),
            .MEM_WORDS      (1024),
            .GNT_WAIT       (G_OF[k]),
            .RVALID_LATENCY (L_OF[k])
        ) u_dut (
            .clk           (clk),
            .reset         (rst[k]),
            .data_req_i    (req[k]),
            .data_addr_i   (addr[k]),
            .data_we_i     (we[k]),
            .data_be_i     (be[k]),
            .data_wdata_i  (wdata[k]),
            .data_gnt_o    (gnt[k]),
            .data_rvalid_o (rvalid[k]),
            .data_rdata_o  (rdata[k]),
            .data_err_o    (err[k]),
            .req_count_o   (cnt[k])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transaction; expected gnt cycle is G, rvalid cycle is G+L.
    task automatic txn(input int k, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d);
        int g = G_OF[k];
        int l = L_OF[k];
        bit in_r;
        int idx;
        logic [31:0] exp_rd;
        logic exp_err;
        in_r    = (a >= BASE) && (a < BASE + SPAN);
        idx     = in_r ? int'((a - BASE) >> 2) : 0;
        exp_err = !in_r;
        exp_rd  = (in_r && !w) ? mm[k][idx] : 32'h0;
        for (int c = 0; c <= g + l; c++) begin
            @(negedge clk);
            if (c <= g) begin
                req[k] = 1'b1; addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d;
            end else begin
                // stale request fields must be ignored while the response is pending
                req[k]   = (c < g + l);
                addr[k]  = $urandom;
                we[k]    = 1'($urandom_range(0, 1));
                be[k]    = 4'($urandom_range(0, 15));
                wdata[k] = $urandom;
            end
            #2;
            check("gnt",    32'(gnt[k]),    32'(c == g));
            check("rvalid", 32'(rvalid[k]), 32'(c == g + l));
            check("rdata",  rdata[k],       (c == g + l) ? exp_rd : 32'h0);
            check("err",    32'(err[k]),    (c == g + l) ? 32'(exp_err) : 32'h0);
            if (c == g) begin
                exp_cnt[k] = exp_cnt[k] + 32'd1;
                if (w && in_r) begin
                    for (int i = 0; i < 4; i++)
                        if (b[i]) mm[k][idx][8*i +: 8] = d[8*i +: 8];
                end
            end
            if (c == g + l) check("count", cnt[k], exp_cnt[k]);
        end
    endtask

    // Request dropped before the grant delay expires: never serviced.
    task automatic abandon(input int k);
        int n = int'($urandom_range(1, G_OF[k]));
        for (int c = 0; c < n + 2; c++) begin
            @(negedge clk);
            req[k] = (c < n); addr[k] = BASE; we[k] = 1'b1; be[k] = 4'hF; wdata[k] = $urandom;
            #2;
            check("abandon_gnt",    32'(gnt[k]),    32'h0);
            check("abandon_rvalid", 32'(rvalid[k]), 32'h0);
            check("abandon_count",  cnt[k],         exp_cnt[k]);
        end
    endtask

    // Write handshake followed by reset before its response.
    task automatic reset_mid(input int k, input logic [31:0] a, input logic [31:0] d);
        int g = G_OF[k];
        int idx = int'((a - BASE) >> 2);
        for (int c = 0; c <= g; c++) begin
            @(negedge clk);
            req[k] = 1'b1; addr[k] = a; we[k] = 1'b1; be[k] = 4'hF; wdata[k] = d;
            #2;
            check("rm_gnt", 32'(gnt[k]), 32'(c == g));
        end
        mm[k][idx] = d;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst[k] = 1'b1; req[k] = 1'b1; addr[k] = a; we[k] = 1'b0;
            #2;
            check("rm_rst_gnt",    32'(gnt[k]),    32'h0);
            check("rm_rst_rvalid", 32'(rvalid[k]), 32'h0);
        end
        exp_cnt[k] = 32'h0;
        for (int c = 0; c < L_OF[k] + 2; c++) begin
            @(negedge clk);
            rst[k] = 1'b0; req[k] = 1'b0;
            #2;
            check("rm_rvalid", 32'(rvalid[k]), 32'h0);
            check("rm_rdata",  rdata[k],       32'h0);
            check("rm_err",    32'(err[k]),    32'h0);
            check("rm_count",  cnt[k],         32'h0);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] lo = 32'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0:       return 32'h0000_27FC + lo;
            1:       return 32'h0000_3800 + lo;
            2:       return 32'hFFFF_FFFC;
            3:       return BASE + SPAN - 32'd4 + lo;
            default: return BASE + 32'($urandom_range(0, 15)) * 32'd4 + lo;
        endcase
    endfunction

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0;
            be[k] = '0; wdata[k] = '0; exp_cnt[k] = '0;
            for (int i = 0; i < 1024; i++) mm[k][i] = 32'h0;
        end
        req[0] = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        for (int k = 0; k < NI; k++) begin
            check("rst_gnt",    32'(gnt[k]),    32'h0);
            check("rst_rvalid", 32'(rvalid[k]), 32'h0);
            check("rst_rdata",  rdata[k],       32'h0);
            check("rst_err",    32'(err[k]),    32'h0);
            check("rst_count",  cnt[k],         32'h0);
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b0; req[k] = 1'b0;
        end

        // default timing, basic write/read, byte lanes, out of range
        txn(0, 32'h2804, 1'b1, 4'hF, 32'hDEAD_BEEF);
        txn(0, 32'h2804, 1'b0, 4'h0, 32'h0);
        check("count_after_two", cnt[0], 32'd2);
        txn(0, 32'h2810, 1'b1, 4'hF, 32'h1122_3344);
        txn(0, 32'h2810, 1'b1, 4'b0100, 32'h00AA_0000);
        txn(0, 32'h2810, 1'b0, 4'hF, 32'h0);
        txn(0, 32'h2810, 1'b1, 4'b0000, 32'hFFFF_FFFF);
        txn(0, 32'h2810, 1'b0, 4'h0, 32'h0);
        txn(0, 32'h2800, 1'b1, 4'hF, 32'hCAFE_F00D);
        txn(0, 32'h27FC, 1'b0, 4'hF, 32'h0);
        txn(0, 32'h3800, 1'b1, 4'hF, 32'h5555_AAAA);
        txn(0, 32'h2800, 1'b0, 4'hF, 32'h0);

        // stretched grant and latency
        txn(1, 32'h2804, 1'b1, 4'hF, 32'h0BAD_F00D);
        txn(1, 32'h2804, 1'b0, 4'h0, 32'h0);
        abandon(1);
        abandon(2);
        txn(2, 32'h2808, 1'b1, 4'hF, 32'h1357_9BDF);
        txn(2, 32'h2808, 1'b0, 4'h0, 32'h0);

        reset_mid(2, 32'h2820, 32'h5A5A_1234);
        txn(2, 32'h2820, 1'b0, 4'hF, 32'h0);

        // randomised traffic over a small working set plus the last word
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 16; i++)
                txn(k, BASE + 32'(i) * 32'd4, 1'b1, 4'hF, $urandom);
            txn(k, BASE + SPAN - 32'd4, 1'b1, 4'hF, $urandom);
        end
        for (int n = 0; n < 150; n++) begin
            int k = int'($urandom_range(0, NI - 1));
            if (G_OF[k] > 0 && $urandom_range(0, 7) == 0) abandon(k);
            else txn(k, pick_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
